bus_xfer_sequencer: RTL

//  Control-side counterpart of the 32-bit datapath bus mux. Accepts queued register-transfer

---
 rtl/bus_xfer_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bus_xfer_sequencer.sv
// Register-transfer sequencer: queues {src,dst} codes and issues a one-hot bus drive enable,
// then a one-hot load strobe on the following cycle so the bus settles before capture.
module bus_xfer_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned N_SRC      = 24,
    parameter int unsigned N_DST      = 24
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_src,
    input  logic [4:0]       cmd_dst,
    input  logic             stall,
    output logic [N_SRC-1:0] src_enable,
    output logic [N_DST-1:0] dst_load,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam int unsigned CODE_W = 5;
    localparam int unsigned ENT_W  = 2 * CODE_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [CODE_W:0]  SRC_LIM = N_SRC[CODE_W:0];
    localparam logic [CODE_W:0]  DST_LIM = N_DST[CODE_W:0];
    localparam logic [CNT_W-1:0] FULL_CNT = FIFO_DEPTH[CNT_W-1:0];
    localparam logic [N_SRC-1:0] SRC_ONE = {{(N_SRC-1){1'b0}}, 1'b1};
    localparam logic [N_DST-1:0] DST_ONE = {{(N_DST-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [CODE_W-1:0] cur_src, cur_dst, src_nxt, dst_nxt;
    logic [CODE_W-1:0] head_src, head_dst;
    logic              head_ok, push, pop;
    logic [N_SRC-1:0]  src_enable_nxt;
    logic [N_DST-1:0]  dst_load_nxt;
    logic              done_nxt, err_nxt, busy_nxt, ready_nxt;

    assign push     = cmd_valid & cmd_ready;
    assign head_src = mem[rd_ptr][ENT_W-1:CODE_W];
    assign head_dst = mem[rd_ptr][CODE_W-1:0];
    assign head_ok  = ({1'b0, head_src} < SRC_LIM) && ({1'b0, head_dst} < DST_LIM);

    // Queue storage; flushing is done through the pointers, so the array needs no reset.
    always_ff @(posedge clock) begin
        if (!clear && push) begin
            mem[wr_ptr] <= {cmd_src, cmd_dst};
        end
    end

    // State, queue bookkeeping and registered outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cur_src    <= '0;
            cur_dst    <= '0;
            src_enable <= '0;
            dst_load   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            state      <= state_nxt;
            cur_src    <= src_nxt;
            cur_dst    <= dst_nxt;
            count      <= count_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            src_enable <= src_enable_nxt;
            dst_load   <= dst_load_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
            cmd_ready  <= ready_nxt;
        end
    end

    // Next state: IDLE, LOAD and ERR all pick up the queue head the same way.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (!stall) begin
            case (state)
                DRIVE: state_nxt = LOAD;
                default: begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = head_ok ? DRIVE : ERR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // Output decode from the upcoming state/command, so the outputs themselves are flops.
    always_comb begin
        src_nxt        = pop ? head_src : cur_src;
        dst_nxt        = pop ? head_dst : cur_dst;
        src_enable_nxt = '0;
        dst_load_nxt   = '0;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        case (state_nxt)
            DRIVE: src_enable_nxt = SRC_ONE << src_nxt;
            LOAD: begin
                src_enable_nxt = SRC_ONE << src_nxt;
                dst_load_nxt   = DST_ONE << dst_nxt;
                done_nxt       = 1'b1;
            end
            ERR:     err_nxt = 1'b1;
            default: ;
        endcase
        count_nxt = count;
        if (push && !pop)      count_nxt = count + CNT_W'(1);
        else if (!push && pop) count_nxt = count - CNT_W'(1);
        busy_nxt  = (count_nxt != '0) || (state_nxt != IDLE);
        ready_nxt = (count_nxt != FULL_CNT);
    end

endmodule
